bus_initiator: RTL and testbench
================================

BUS_INITIATOR -- requirements
Module: bus_initiator

Interface
REQ-001 Parameter CLK_DIV, default 6, ref_clk cycles per wb_clk half-period (12 MHz -> 1 MHz bus clock); legal range 1..255.
REQ-002 Parameter TIMEOUT_TICKS, default 16, wb_clk rising edges allowed for wb_ack before abort; legal range 1..255.
REQ-003 ref_clk  input  1  single system clock; all state on its rising edge.
REQ-004 reset_n  input  1  asynchronous, active-low reset.
REQ-005 req_valid  input  1  request present; req_ready  output  1  module can accept a request.
REQ-006 req_we  input  1  1=write, 0=read; req_addr  input  2  register address; req_wdata  input  8  write data.
REQ-007 rsp_valid  output  1  one-cycle response strobe; rsp_rdata  output  8  read data; rsp_err  output  1  timeout flag, valid with rsp_valid.
REQ-008 wb_clk  output  1  generated bus clock; wb_stb  output  1  chip select; wb_we  output  1; wb_addr  output  2; wb_data_out  output  8.
REQ-009 wb_data_in  input  8  responder read data; wb_ack  input  1  responder acknowledge.

Function
REQ-010 Divider counter 0..CLK_DIV-1 runs continuously; at terminal count it resets and wb_clk toggles.
REQ-011 "Rise tick" = ref_clk cycle where wb_clk toggles 0->1; "fall tick" = toggle 1->0.
REQ-012 States: IDLE, SETUP, ACTIVE, RELEASE, DONE; req_ready SHALL be 1 only in IDLE.
REQ-013 IDLE: on req_valid&&req_ready, latch req_we/req_addr/req_wdata, go SETUP.
REQ-014 SETUP: at next fall tick drive wb_addr, wb_we, wb_data_out (req_wdata on write, 0x00 on read), wb_stb=1; go ACTIVE, clear tick counter.
REQ-015 ACTIVE: at each rise tick sample wb_ack; if 1, capture wb_data_in into rsp_rdata (read only; write leaves rsp_rdata unchanged), rsp_err=0, go RELEASE.
REQ-016 RELEASE: at next fall tick wb_stb=0, wb_we=0; go DONE.
REQ-017 DONE: rsp_valid=1 for exactly one ref_clk cycle; go IDLE next cycle.
REQ-018 wb_addr, wb_we, wb_data_out SHALL be stable whenever wb_stb=1; bus outputs change only on fall ticks.
REQ-019 wb_ack outside ACTIVE or between rise ticks SHALL be ignored.
REQ-020 Requests arriving while req_ready=0 SHALL not be latched; no queueing.
REQ-021 Latency accept->wb_stb high: at most 2*CLK_DIV ref_clk cycles.

Reset
REQ-022 While reset_n=0, immediately: wb_clk=0, wb_stb=0, wb_we=0, wb_addr=0, wb_data_out=0x00, req_ready=0, rsp_valid=0, rsp_rdata=0x00, rsp_err=0, divider=0, state IDLE.
REQ-023 req_ready SHALL rise on the first ref_clk edge after reset_n deasserts.
REQ-024 Reset mid-cycle SHALL abort the transaction without a response; wb_stb drops asynchronously.

Configuration
REQ-025 Macro BUS_INITIATOR_TIMEOUT_EN: when defined, ACTIVE counts rise ticks with wb_ack=0; on reaching TIMEOUT_TICKS go RELEASE with rsp_err=1, rsp_rdata=0x00.
REQ-026 When BUS_INITIATOR_TIMEOUT_EN undefined, ACTIVE waits indefinitely for wb_ack; rsp_err tied 0; no timeout counter synthesized.

Verification
REQ-027 Write: CLK_DIV=6, req we=1 addr=2 wdata=0xA5, wb_ack high on 1st rise tick -> wb_stb high with addr=2, data_out=0xA5 stable; rsp_valid 1 cycle, rsp_err=0.
REQ-028 Read: req we=0 addr=1, wb_data_in=0x3C, ack on 3rd rise tick -> rsp_rdata=0x3C, exactly 3 rise ticks with wb_stb=1 before RELEASE.
REQ-029 Timeout (macro defined, TIMEOUT_TICKS=4): wb_ack held 0 -> wb_stb drops at fall tick after 4th rise tick; rsp_valid with rsp_err=1, rsp_rdata=0x00.
REQ-030 Backpressure: req_valid held high with new data during transaction -> req_ready=0, second request accepted only after DONE, bus shows second request's values.
REQ-031 Reset: assert reset_n=0 while wb_stb=1 -> wb_stb, wb_clk 0 same cycle, no rsp_valid; after release req_ready=1 next edge.
REQ-032 Spurious ack: wb_ack pulsed in IDLE -> no state change, rsp_valid stays 0.

Source files
------------

// File: rtl/bus_initiator.sv
// bus_initiator: turns single register requests into slow-clock strobe/ack bus cycles
//
// Ports
//   ref_clk, reset_n           system clock, asynchronous active-low reset
//   req_valid/req_ready        request handshake; req_we, req_addr, req_wdata carry the request
//   rsp_valid                  one-cycle response strobe with rsp_rdata and rsp_err
//   wb_clk                     divided bus clock (CLK_DIV ref_clk cycles per half-period)
//   wb_stb, wb_we, wb_addr,
//   wb_data_out                bus outputs, updated only on wb_clk falling ticks
//   wb_data_in, wb_ack         responder read data and acknowledge, sampled on rising ticks
//
// Optional feature: define BUS_INITIATOR_TIMEOUT_EN to abort a cycle after
// TIMEOUT_TICKS unacknowledged rising ticks and report it through rsp_err.
module bus_initiator #(
  parameter int CLK_DIV       = 6,
  parameter int TIMEOUT_TICKS = 16
) (
  input  logic       ref_clk,
  input  logic       reset_n,
  input  logic       req_valid,
  output logic       req_ready,
  input  logic       req_we,
  input  logic [1:0] req_addr,
  input  logic [7:0] req_wdata,
  output logic       rsp_valid,
  output logic [7:0] rsp_rdata,
  output logic       rsp_err,
  output logic       wb_clk,
  output logic       wb_stb,
  output logic       wb_we,
  output logic [1:0] wb_addr,
  output logic [7:0] wb_data_out,
  input  logic [7:0] wb_data_in,
  input  logic       wb_ack
);

  if (CLK_DIV < 1 || CLK_DIV > 255 || TIMEOUT_TICKS < 1 || TIMEOUT_TICKS > 255) begin : g_bad_param
    $error("bus_initiator: CLK_DIV and TIMEOUT_TICKS must lie in 1..255");
  end

  localparam logic [7:0] DIV_MAX = 8'(CLK_DIV - 1);

  typedef enum logic [2:0] {IDLE, SETUP, ACTIVE, RELEASE, DONE} state_t;

  state_t     state_q;
  logic [7:0] div_q, div_d;
  logic       wb_clk_q, wb_clk_d;
  logic       term, rise_tick, fall_tick;
  logic       we_q;
  logic [1:0] addr_q;
  logic [7:0] wdata_q;
  logic       req_ready_q, rsp_valid_q;
  logic [7:0] rsp_rdata_q;
  logic       wb_stb_q, wb_we_q;
  logic [1:0] wb_addr_q;
  logic [7:0] wb_data_q;

`ifdef BUS_INITIATOR_TIMEOUT_EN
  localparam logic [7:0] TO_MAX = 8'(TIMEOUT_TICKS - 1);
  logic [7:0] to_q;
  logic       rsp_err_q;
  assign rsp_err = rsp_err_q;
`else
  assign rsp_err = 1'b0;
`endif

  // Ticks are the ref_clk cycles in which wb_clk is about to toggle, so bus
  // updates land on the same edge as the corresponding wb_clk transition.
  always_comb begin
    term      = div_q == DIV_MAX;
    div_d     = term ? 8'd0 : div_q + 8'd1;
    wb_clk_d  = wb_clk_q ^ term;
    rise_tick = term & ~wb_clk_q;
    fall_tick = term & wb_clk_q;
  end

  always_ff @(posedge ref_clk or negedge reset_n) begin
    if (!reset_n) begin
      div_q    <= 8'd0;
      wb_clk_q <= 1'b0;
    end else begin
      div_q    <= div_d;
      wb_clk_q <= wb_clk_d;
    end
  end

  always_ff @(posedge ref_clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      we_q        <= 1'b0;
      addr_q      <= 2'd0;
      wdata_q     <= 8'h00;
      req_ready_q <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_rdata_q <= 8'h00;
      wb_stb_q    <= 1'b0;
      wb_we_q     <= 1'b0;
      wb_addr_q   <= 2'd0;
      wb_data_q   <= 8'h00;
`ifdef BUS_INITIATOR_TIMEOUT_EN
      to_q        <= 8'd0;
      rsp_err_q   <= 1'b0;
`endif
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        IDLE: begin
          // ready comes up one edge after reset release and stays up while idle
          req_ready_q <= 1'b1;
          if (req_valid && req_ready_q) begin
            we_q        <= req_we;
            addr_q      <= req_addr;
            wdata_q     <= req_wdata;
            req_ready_q <= 1'b0;
            state_q     <= SETUP;
          end
        end
        SETUP: if (fall_tick) begin
          wb_stb_q  <= 1'b1;
          wb_we_q   <= we_q;
          wb_addr_q <= addr_q;
          wb_data_q <= we_q ? wdata_q : 8'h00;
          state_q   <= ACTIVE;
`ifdef BUS_INITIATOR_TIMEOUT_EN
          to_q      <= 8'd0;
`endif
        end
        ACTIVE: if (rise_tick) begin
          if (wb_ack) begin
            if (!we_q) rsp_rdata_q <= wb_data_in;
`ifdef BUS_INITIATOR_TIMEOUT_EN
            rsp_err_q <= 1'b0;
`endif
            state_q <= RELEASE;
          end
`ifdef BUS_INITIATOR_TIMEOUT_EN
          else if (to_q == TO_MAX) begin
            rsp_err_q   <= 1'b1;
            rsp_rdata_q <= 8'h00;
            state_q     <= RELEASE;
          end else begin
            to_q <= to_q + 8'd1;
          end
`endif
        end
        RELEASE: if (fall_tick) begin
          wb_stb_q    <= 1'b0;
          wb_we_q     <= 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= DONE;
        end
        DONE: begin
          req_ready_q <= 1'b1;
          state_q     <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign req_ready   = req_ready_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_rdata   = rsp_rdata_q;
  assign wb_clk      = wb_clk_q;
  assign wb_stb      = wb_stb_q;
  assign wb_we       = wb_we_q;
  assign wb_addr     = wb_addr_q;
  assign wb_data_out = wb_data_q;

endmodule

// File: tb/tb_bus_initiator.sv
// tb_bus_initiator: directed and randomized self-checking bench for bus_initiator
module tb_bus_initiator;
  localparam int D  = 6;
  localparam int TO = 4;

  logic       ref_clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       req_valid = 1'b0;
  logic       req_ready;
  logic       req_we = 1'b0;
  logic [1:0] req_addr = 2'd0;
  logic [7:0] req_wdata = 8'h00;
  logic       rsp_valid;
  logic [7:0] rsp_rdata;
  logic       rsp_err;
  logic       wb_clk;
  logic       wb_stb;
  logic       wb_we;
  logic [1:0] wb_addr;
  logic [7:0] wb_data_out;
  logic [7:0] wb_data_in = 8'h00;
  logic       wb_ack = 1'b0;

  int         n_assert = 0;
  int         n_fail = 0;
  int         cyc = 0;
  logic       chk = 1'b0;
  logic       pclk = 1'b0;
  logic [7:0] last_rd = 8'h00;

  bus_initiator #(.CLK_DIV(D), .TIMEOUT_TICKS(TO)) dut (
    .ref_clk(ref_clk), .reset_n(reset_n),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_we(req_we), .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
    .wb_clk(wb_clk), .wb_stb(wb_stb), .wb_we(wb_we), .wb_addr(wb_addr),
    .wb_data_out(wb_data_out), .wb_data_in(wb_data_in), .wb_ack(wb_ack)
  );

  always #5 ref_clk = ~ref_clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one ref_clk edge and sample 1 time unit later; the bus clock
  // after k edges from reset release is (k / D) mod 2.
  task automatic step();
    pclk = wb_clk;
    @(posedge ref_clk);
    #1;
    cyc++;
    if (chk) check("wb_clk_divider", 32'(wb_clk), (cyc / D) % 2);
  endtask

  task automatic issue(input logic we, input logic [1:0] addr, input logic [7:0] wdata);
    int w;
    w = 0;
    while (!req_ready && w < 4 * D) begin
      step();
      w++;
    end
    check("ready_before_issue", 32'(req_ready), 1);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    step();
    req_valid = 1'b0;
    check("ready_after_accept", 32'(req_ready), 0);
  endtask

  // nack = rising tick (counted from 1) on which the responder acknowledges; 0 = never.
  task automatic bus(input logic we, input logic [1:0] addr, input logic [7:0] wdata,
                     input logic [7:0] din, input int nack);
    int lat, rises, budget;
    logic stable;
    logic [7:0] exp_do;
    exp_do = we ? wdata : 8'h00;
    wb_data_in = din;
    wb_ack = 1'b0;
    lat = 0;
    while (!wb_stb && lat <= 2 * D) begin
      step();
      lat++;
    end
    check("stb_rise", 32'(wb_stb), 1);
    check("setup_latency", 32'(lat <= 2 * D), 1);
    check("stb_rise_on_fall_tick", 32'({pclk, wb_clk}), 2);
    check("wb_addr", 32'(wb_addr), 32'(addr));
    check("wb_we", 32'(wb_we), 32'(we));
    check("wb_data_out", 32'(wb_data_out), 32'(exp_do));
    rises = 0;
    stable = 1'b1;
    budget = 0;
    wb_ack = (nack == 1);
    while (wb_stb && budget < 2 * D * (nack + TO + 2)) begin
      step();
      budget++;
      if (wb_clk && !pclk) rises++;
      wb_ack = (nack != 0) && (rises == nack - 1);
      if (wb_stb && (wb_addr !== addr || wb_we !== we || wb_data_out !== exp_do || req_ready !== 1'b0))
        stable = 1'b0;
    end
    wb_ack = 1'b0;
    check("stb_fall", 32'(wb_stb), 0);
    check("stb_drop_on_fall_tick", 32'({pclk, wb_clk}), 2);
    check("rise_ticks_with_stb", rises, (nack == 0) ? TO : nack);
    check("bus_stable_while_stb", 32'(stable), 1);
    check("wb_we_released", 32'(wb_we), 0);
    if (nack == 0) last_rd = 8'h00;
    else if (!we) last_rd = din;
    check("rsp_valid_high", 32'(rsp_valid), 1);
    check("rsp_rdata", 32'(rsp_rdata), 32'(last_rd));
    check("rsp_err", 32'(rsp_err), 32'(nack == 0));
    step();
    check("rsp_valid_one_cycle", 32'(rsp_valid), 0);
    check("ready_after_done", 32'(req_ready), 1);
  endtask

  initial begin
    logic       we;
    logic [1:0] addr;
    logic [7:0] wdata, din;
    int         nack, w;

    // reset state
    #23;
    check("rst_wb_clk", 32'(wb_clk), 0);
    check("rst_wb_stb", 32'(wb_stb), 0);
    check("rst_wb_we", 32'(wb_we), 0);
    check("rst_wb_addr", 32'(wb_addr), 0);
    check("rst_wb_data_out", 32'(wb_data_out), 0);
    check("rst_req_ready", 32'(req_ready), 0);
    check("rst_rsp_valid", 32'(rsp_valid), 0);
    check("rst_rsp_rdata", 32'(rsp_rdata), 0);
    check("rst_rsp_err", 32'(rsp_err), 0);
    step();
    reset_n = 1'b1;
    cyc = 0;
    chk = 1'b1;
    step();
    check("ready_first_edge", 32'(req_ready), 1);

    // spurious ack while idle
    wb_ack = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      check("spurious_rsp_valid", 32'(rsp_valid), 0);
      check("spurious_stb", 32'(wb_stb), 0);
      check("spurious_ready", 32'(req_ready), 1);
    end
    wb_ack = 1'b0;

    // directed write, ack on 1st rising tick
    issue(1'b1, 2'd2, 8'hA5);
    bus(1'b1, 2'd2, 8'hA5, 8'h77, 1);

    // directed read, ack on 3rd rising tick
    issue(1'b0, 2'd1, 8'hEE);
    bus(1'b0, 2'd1, 8'hEE, 8'h3C, 3);

    // backpressure: a second request held during the first transaction
    issue(1'b0, 2'd3, 8'h00);
    req_valid = 1'b1;
    req_we    = 1'b1;
    req_addr  = 2'd0;
    req_wdata = 8'h5A;
    bus(1'b0, 2'd3, 8'h00, 8'hC3, 2);
    step();
    req_valid = 1'b0;
    check("bp_second_accepted", 32'(req_ready), 0);
    bus(1'b1, 2'd0, 8'h5A, 8'h11, 1);

`ifdef BUS_INITIATOR_TIMEOUT_EN
    // no acknowledge at all
    issue(1'b0, 2'd2, 8'h00);
    bus(1'b0, 2'd2, 8'h00, 8'h99, 0);
`endif

    // randomized transactions
    for (int t = 0; t < 10; t++) begin
      we    = 1'($urandom);
      addr  = 2'($urandom);
      wdata = 8'($urandom);
      din   = 8'($urandom);
`ifdef BUS_INITIATOR_TIMEOUT_EN
      nack  = int'($urandom_range(0, 4));
`else
      nack  = int'($urandom_range(1, 4));
`endif
      for (int g = 0; g < int'($urandom_range(0, 3)); g++) step();
      issue(we, addr, wdata);
      bus(we, addr, wdata, din, nack);
    end

    // reset while the strobe is high
    issue(1'b1, 2'd1, 8'h42);
    w = 0;
    while (!wb_stb && w <= 2 * D) begin
      step();
      w++;
    end
    check("pre_reset_stb", 32'(wb_stb), 1);
    chk = 1'b0;
    reset_n = 1'b0;
    #1;
    check("reset_stb_drop", 32'(wb_stb), 0);
    check("reset_wb_clk", 32'(wb_clk), 0);
    check("reset_ready", 32'(req_ready), 0);
    check("reset_rsp_valid", 32'(rsp_valid), 0);
    last_rd = 8'h00;
    for (int i = 0; i < 3; i++) begin
      step();
      check("reset_no_rsp", 32'(rsp_valid), 0);
    end
    reset_n = 1'b1;
    cyc = 0;
    chk = 1'b1;
    step();
    check("ready_after_reset", 32'(req_ready), 1);
    check("rdata_after_reset", 32'(rsp_rdata), 0);

    // normal operation resumes
    issue(1'b0, 2'd0, 8'h00);
    bus(1'b0, 2'd0, 8'h00, 8'hB7, 2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
